// File: rtl/vend_pkg.sv
`default_nettype none
// vend_pkg - shared state encoding, coin codes and credit width for vend_ctrl.
// Rev 1.0
package vend_pkg;

  localparam int CREDIT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_CHANGE   = 3'd5
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_2  = 2'd1;
  localparam logic [1:0] COIN_5  = 2'd2;
  localparam logic [1:0] COIN_10 = 2'd3;

  localparam logic [1:0] PRODUCT_INVALID = 2'd3;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  coin_value = 5'd1;
      COIN_2:  coin_value = 5'd2;
      COIN_5:  coin_value = 5'd5;
      default: coin_value = 5'd10;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_credit_acc.sv
`default_nettype none
// vend_credit_acc - credit register with coin decode, CREDIT_MAX limit, subtract and clear.
// Rev 1.0
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CREDIT_MAX = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                coin_en,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_amt,
  input  logic                clr,
  output logic                coin_accept,
  output logic [CREDIT_W-1:0] credit_plus,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W + 1)'(CREDIT_MAX);

  // One extra bit so the limit check cannot wrap when CREDIT_MAX is near 31.
  logic [CREDIT_W:0] sum;

  assign sum         = {1'b0, credit} + {1'b0, coin_value(coin_type)};
  assign coin_accept = coin_valid && coin_en && (sum <= MAX_EXT);
  assign credit_plus = coin_accept ? sum[CREDIT_W-1:0] : credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= '0;
    end else if (clr) begin
      credit <= '0;
    end else if (sub_en) begin
      credit <= credit - sub_amt;
    end else begin
      credit <= credit_plus;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// vend_ctrl - vending sequencer: coin credit, price lookup, dispense and change handshake.
// Rev 1.0; define VEND_TIMEOUT_EN to auto-refund credit after TIMEOUT_CYCLES idle cycles.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_MAX     = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic [1:0] rom_addr,
  input  logic [3:0] rom_price,
  output logic       coin_reject,
  output logic       sel_err,
  output logic       insufficient,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic       change_valid,
  output logic [4:0] change_amt,
  input  logic       change_ack,
  output logic [4:0] credit,
  output logic       busy
);

  state_t state, state_n;

  logic [CREDIT_W-1:0] price_q, price_n;
  logic [CREDIT_W-1:0] change_n;
  logic [CREDIT_W-1:0] credit_plus;
  logic [1:0]          rom_addr_n;
  logic                sel_err_n, insuf_n;
  logic                coin_en, sub_en, clr, coin_accept, timeout;

  vend_credit_acc #(
    .CREDIT_MAX (CREDIT_MAX)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .coin_en     (coin_en),
    .sub_en      (sub_en),
    .sub_amt     (price_q),
    .clr         (clr),
    .coin_accept (coin_accept),
    .credit_plus (credit_plus),
    .credit      (credit)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;

  assign timeout = (state == ST_COLLECT) && (idle_cnt == TO_LAST) &&
                   !coin_accept && !sel_valid && !cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != ST_COLLECT || coin_accept || sel_valid || cancel || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    rom_addr_n = rom_addr;
    price_n    = price_q;
    change_n   = change_amt;
    sel_err_n  = 1'b0;
    insuf_n    = 1'b0;
    coin_en    = 1'b0;
    sub_en     = 1'b0;
    clr        = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        coin_en = 1'b1;
        // A coin arriving with cancel/selection is already folded into credit_plus.
        if (cancel || timeout) begin
          if (credit_plus != '0) begin
            clr      = 1'b1;
            change_n = credit_plus;
            state_n  = ST_CHANGE;
          end else begin
            state_n  = ST_IDLE;
          end
        end else if (sel_valid && sel != PRODUCT_INVALID) begin
          rom_addr_n = sel;
          state_n    = ST_LOOKUP;
        end else begin
          sel_err_n = sel_valid;
          state_n   = (credit_plus != '0) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        price_n = {1'b0, rom_price};
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (credit >= price_q) begin
          sub_en  = 1'b1;
          state_n = ST_DISPENSE;
        end else begin
          insuf_n = 1'b1;
          state_n = (credit != '0) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (credit != '0) begin
          clr      = 1'b1;
          change_n = credit;
          state_n  = ST_CHANGE;
        end else begin
          state_n  = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (change_ack) begin
          change_n = '0;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rom_addr     <= '0;
      price_q      <= '0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_n;
      rom_addr     <= rom_addr_n;
      price_q      <= price_n;
      change_amt   <= change_n;
      coin_reject  <= coin_valid && !coin_accept;
      sel_err      <= sel_err_n;
      insufficient <= insuf_n;
    end
  end

  assign dispense     = (state == ST_DISPENSE);
  assign dispense_id  = dispense ? rom_addr : 2'd0;
  assign change_valid = (state == ST_CHANGE);
  assign busy         = (state == ST_LOOKUP) || (state == ST_CHECK) ||
                        (state == ST_DISPENSE) || (state == ST_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// tb_vend_ctrl - directed self-checking bench for vend_ctrl with a behavioural price ROM.
// Rev 1.0
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [1:0] rom_addr;
  logic [3:0] rom_price;
  logic       coin_reject, sel_err, insufficient, dispense, change_valid, busy;
  logic [1:0] dispense_id;
  logic [4:0] change_amt, credit;
  logic [19:0] all_outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rom_price = (rom_addr == 2'd0) ? 4'd5 :
                     (rom_addr == 2'd1) ? 4'd10 :
                     (rom_addr == 2'd2) ? 4'd15 : 4'd0;

  assign all_outs = {rom_addr, coin_reject, sel_err, insufficient, dispense, dispense_id,
                     change_valid, change_amt, credit, busy};

  vend_ctrl #(
    .CREDIT_MAX     (20),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .rom_addr     (rom_addr),
    .rom_price    (rom_price),
    .coin_reject  (coin_reject),
    .sel_err      (sel_err),
    .insufficient (insufficient),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ack   (change_ack),
    .credit       (credit),
    .busy         (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic do_ack;
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    total++;
    if (all_outs !== 20'd0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || credit !== 5'd0) begin
      bad++; $display("FAIL reset_release: busy=%b credit=%0d want 0/0", busy, credit);
    end
  endtask

  task automatic test_exact_pay;
    put_coin(2'd3);
    put_coin(2'd2);
    total++;
    if (credit !== 5'd15) begin
      bad++; $display("FAIL exact_credit: got %0d want 15", credit);
    end
    sel_valid = 1'b1; sel = 2'd2;
    tick();
    sel_valid = 1'b0;
    total++;
    if (rom_addr !== 2'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL exact_lookup: rom_addr=%0d busy=%b want 2/1", rom_addr, busy);
    end
    tick();
    total++;
    if (dispense !== 1'b0) begin
      bad++; $display("FAIL exact_early_dispense: got %b want 0", dispense);
    end
    tick();
    total++;
    if (dispense !== 1'b1 || dispense_id !== 2'd2 || credit !== 5'd0) begin
      bad++; $display("FAIL exact_dispense: disp=%b id=%0d credit=%0d want 1/2/0",
                      dispense, dispense_id, credit);
    end
    tick();
    total++;
    if (dispense !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL exact_after: disp=%b cv=%b busy=%b want 0/0/0",
                      dispense, change_valid, busy);
    end
  endtask

  task automatic test_change;
    put_coin(2'd3);
    put_coin(2'd3);
    total++;
    if (credit !== 5'd20) begin
      bad++; $display("FAIL change_credit: got %0d want 20", credit);
    end
    sel_valid = 1'b1; sel = 2'd0;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    total++;
    if (dispense !== 1'b1 || dispense_id !== 2'd0 || credit !== 5'd15) begin
      bad++; $display("FAIL change_dispense: disp=%b id=%0d credit=%0d want 1/0/15",
                      dispense, dispense_id, credit);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (change_valid !== 1'b1 || change_amt !== 5'd15 || credit !== 5'd0) begin
        bad++; $display("FAIL change_hold[%0d]: cv=%b amt=%0d credit=%0d want 1/15/0",
                        i, change_valid, change_amt, credit);
      end
      if (i < 4) tick();
    end
    do_ack();
    total++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL change_ack: cv=%b busy=%b want 0/0", change_valid, busy);
    end
  endtask

  task automatic test_insufficient;
    put_coin(2'd2);
    sel_valid = 1'b1; sel = 2'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    total++;
    if (insufficient !== 1'b1 || credit !== 5'd5 || busy !== 1'b0 || dispense !== 1'b0) begin
      bad++; $display("FAIL insuf_pulse: insuf=%b credit=%0d busy=%b disp=%b want 1/5/0/0",
                      insufficient, credit, busy, dispense);
    end
    tick();
    total++;
    if (insufficient !== 1'b0) begin
      bad++; $display("FAIL insuf_one_cycle: got %b want 0", insufficient);
    end
    put_coin(2'd2);
    sel_valid = 1'b1; sel = 2'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    total++;
    if (dispense !== 1'b1 || dispense_id !== 2'd1 || credit !== 5'd0) begin
      bad++; $display("FAIL insuf_retry: disp=%b id=%0d credit=%0d want 1/1/0",
                      dispense, dispense_id, credit);
    end
    tick();
    total++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL insuf_no_change: cv=%b busy=%b want 0/0", change_valid, busy);
    end
  endtask

  task automatic test_boundaries;
    put_coin(2'd3);
    put_coin(2'd3);
    put_coin(2'd0);
    total++;
    if (coin_reject !== 1'b1 || credit !== 5'd20) begin
      bad++; $display("FAIL max_reject: rej=%b credit=%0d want 1/20", coin_reject, credit);
    end
    sel_valid = 1'b1; sel = 2'd3;
    tick();
    sel_valid = 1'b0;
    total++;
    if (sel_err !== 1'b1 || busy !== 1'b0 || rom_addr !== 2'd1 || coin_reject !== 1'b0) begin
      bad++; $display("FAIL sel_invalid: err=%b busy=%b addr=%0d rej=%b want 1/0/1/0",
                      sel_err, busy, rom_addr, coin_reject);
    end
    tick();
    total++;
    if (sel_err !== 1'b0) begin
      bad++; $display("FAIL sel_err_one_cycle: got %b want 0", sel_err);
    end
    sel_valid = 1'b1; sel = 2'd0;
    tick();
    sel_valid = 1'b0;
    coin_valid = 1'b1; coin_type = 2'd1;
    tick();
    coin_valid = 1'b0;
    total++;
    if (coin_reject !== 1'b1 || credit !== 5'd20) begin
      bad++; $display("FAIL busy_coin: rej=%b credit=%0d want 1/20", coin_reject, credit);
    end
    tick();
    tick();
    total++;
    if (change_valid !== 1'b1 || change_amt !== 5'd15) begin
      bad++; $display("FAIL busy_coin_change: cv=%b amt=%0d want 1/15", change_valid, change_amt);
    end
    do_ack();
  endtask

  task automatic test_back_to_back;
    put_coin(2'd3);
    sel_valid = 1'b1; sel = 2'd2;
    coin_valid = 1'b1; coin_type = 2'd2;
    tick();
    sel_valid = 1'b0; coin_valid = 1'b0;
    total++;
    if (credit !== 5'd15 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_credit: credit=%0d busy=%b want 15/1", credit, busy);
    end
    tick();
    tick();
    total++;
    if (dispense !== 1'b1 || dispense_id !== 2'd2 || credit !== 5'd0) begin
      bad++; $display("FAIL b2b_dispense: disp=%b id=%0d credit=%0d want 1/2/0",
                      dispense, dispense_id, credit);
    end
    tick();
  endtask

  task automatic test_cancel;
    put_coin(2'd2);
    put_coin(2'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++;
    if (change_valid !== 1'b1 || change_amt !== 5'd7 || credit !== 5'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL cancel_refund: cv=%b amt=%0d credit=%0d busy=%b want 1/7/0/1",
                      change_valid, change_amt, credit, busy);
    end
    do_ack();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL cancel_empty: cv=%b busy=%b want 0/0", change_valid, busy);
    end
  endtask

  task automatic test_reset_mid_change;
    put_coin(2'd3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++;
    if (change_valid !== 1'b1 || change_amt !== 5'd10) begin
      bad++; $display("FAIL rst_setup: cv=%b amt=%0d want 1/10", change_valid, change_amt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== 20'd0) begin
      bad++; $display("FAIL rst_async: got %h want 0", all_outs);
    end
    #2;
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || credit !== 5'd0 || change_valid !== 1'b0) begin
      bad++; $display("FAIL rst_after: busy=%b credit=%0d cv=%b want 0/0/0",
                      busy, credit, change_valid);
    end
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout;
    put_coin(2'd1);
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (change_valid !== 1'b0 || credit !== 5'd2) begin
      bad++; $display("FAIL timeout_early: cv=%b credit=%0d want 0/2", change_valid, credit);
    end
    tick();
    total++;
    if (change_valid !== 1'b1 || change_amt !== 5'd2 || credit !== 5'd0) begin
      bad++; $display("FAIL timeout_refund: cv=%b amt=%0d credit=%0d want 1/2/0",
                      change_valid, change_amt, credit);
    end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_exact_pay();
    test_change();
    test_insufficient();
    test_boundaries();
    test_back_to_back();
    test_cancel();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
